// File: rtl/slam_lif_odometry_if.sv
// TinyQV peripheral bus bundle (address/data/strobes) for the LIF odometry block.
interface slam_lif_odometry_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (output address, data_in, data_write_n, data_read_n,
                  input  data_out, data_ready);
  modport slave  (input  address, data_in, data_write_n, data_read_n,
                  output data_out, data_ready);
endinterface

// File: rtl/slam_lif_odometry.sv
// Multi-axis odometry: spike pairs integrate through LIF membranes, host moves drain from a
// command FIFO, and both feed saturating per-axis positions with sticky bound/overflow flags.
module slam_lif_odometry #(
  parameter int AXES      = 2,
  parameter int POS_W     = 16,
  parameter int MEM_W     = 8,
  parameter int CMD_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         ui_in,
  output logic [7:0]         uo_out,
  output logic               user_interrupt,
  slam_lif_odometry_if.slave bus
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = POS_W + 18;
  localparam int EW = MEM_W + 2;
  localparam int TW = MEM_W - 1;

  function automatic logic signed [MEM_W-1:0] sat_mem(input logic signed [EW-1:0] v);
    logic signed [EW-1:0] hi, lo;
    hi = {3'b000, {TW{1'b1}}};
    lo = {3'b111, {TW{1'b0}}};
    if (v > hi)      return hi[MEM_W-1:0];
    else if (v < lo) return lo[MEM_W-1:0];
    else             return v[MEM_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] mx;
    mx = {{(DW-POS_W){1'b0}}, {POS_W{1'b1}}};
    if (v[DW-1])     return '0;
    else if (v > mx) return '1;
    else             return v[POS_W-1:0];
  endfunction

  logic                    r_enable;
  logic [TW-1:0]           r_thr;
  logic [15:0]             r_leak, r_lcnt;
  logic [POS_W-1:0]        r_bound;
  logic                    r_ovf, r_birq;
  logic [7:0]              r_s1, r_s2, r_fire;
  logic [POS_W-1:0]        r_pos [AXES];
  logic signed [MEM_W-1:0] r_mem [AXES];
  logic [18:0]             r_fifo [CMD_DEPTH];
  logic [AW-1:0]           r_wp, r_rp;
  logic [CW-1:0]           r_cnt;

  logic                    w_wr, w_wr_ctrl, w_wr_leak, w_wr_cmd, w_wr_stat, w_wr_bound, w_sclr;
  logic                    w_empty, w_full, w_pop, w_push_ok, w_ovf_set, w_bnd_set, w_tick;
  logic [7:0]              w_edge, w_fire_nxt;
  logic signed [EW-1:0]    w_thr;
  logic [18:0]             w_head;
  logic signed [EW-1:0]    w_msum [AXES];
  logic signed [DW-1:0]    w_delta [AXES];
  logic signed [MEM_W-1:0] w_mem_nxt [AXES];
  logic [POS_W-1:0]        w_pos_nxt [AXES];
  logic                    w_unused;

  assign w_wr       = bus.data_write_n != 2'b11;
  assign w_wr_ctrl  = w_wr && bus.address == 6'h00;
  assign w_wr_leak  = w_wr && bus.address == 6'h04;
  assign w_wr_cmd   = w_wr && bus.address == 6'h08;
  assign w_wr_stat  = w_wr && bus.address == 6'h0C;
  assign w_wr_bound = w_wr && bus.address == 6'h10;
  assign w_sclr     = w_wr_ctrl && bus.data_in[1];

  assign w_edge    = r_s1 & ~r_s2;
  assign w_thr     = $signed(EW'((r_thr == '0) ? TW'(1) : r_thr));
  assign w_tick    = r_enable && (r_leak != '0) && (r_lcnt >= r_leak - 16'd1);
  assign w_empty   = r_cnt == '0;
  assign w_full    = r_cnt == CW'(CMD_DEPTH);
  assign w_pop     = r_enable && !w_empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign w_push_ok = w_wr_cmd && (!w_full || w_pop);
  assign w_ovf_set = w_wr_cmd && w_full && !w_pop;
  assign w_head    = r_fifo[r_rp];

  assign uo_out         = r_fire;
  assign user_interrupt = r_ovf | r_birq;
  assign bus.data_ready = 1'b1;
  assign w_unused       = ^{bus.data_read_n, bus.data_in[31:19], w_edge};

  always_comb begin
    w_fire_nxt = '0;
    w_bnd_set  = 1'b0;
    for (int a = 0; a < AXES; a++) begin
      w_msum[a] = {{2{r_mem[a][MEM_W-1]}}, r_mem[a]};
      if (w_edge[2*a] && !w_edge[2*a+1])      w_msum[a] = w_msum[a] + EW'(1);
      else if (w_edge[2*a+1] && !w_edge[2*a]) w_msum[a] = w_msum[a] - EW'(1);
      if (w_tick) begin
        if (r_mem[a][MEM_W-1])     w_msum[a] = w_msum[a] + EW'(1);
        else if (r_mem[a] != '0)   w_msum[a] = w_msum[a] - EW'(1);
      end
      w_mem_nxt[a] = sat_mem(w_msum[a]);
      w_delta[a]   = '0;
      if (w_msum[a] >= w_thr) begin
        w_mem_nxt[a]      = '0;
        w_fire_nxt[2*a]   = 1'b1;
        w_delta[a]        = DW'(1);
      end else if (w_msum[a] <= -w_thr) begin
        w_mem_nxt[a]      = '0;
        w_fire_nxt[2*a+1] = 1'b1;
        w_delta[a]        = '1;
      end
      if (w_pop && w_head[17:16] == 2'(a))
        w_delta[a] = w_head[18] ? w_delta[a] - DW'(w_head[15:0]) : w_delta[a] + DW'(w_head[15:0]);
      w_pos_nxt[a] = clamp_pos($signed({{(DW-POS_W){1'b0}}, r_pos[a]}) + w_delta[a]);
      if (r_pos[a] > r_bound) w_bnd_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable <= 1'b0;
      r_thr    <= TW'(4);
      r_leak   <= '0;
      r_lcnt   <= '0;
      r_bound  <= '0;
      r_ovf    <= 1'b0;
      r_birq   <= 1'b0;
      r_s1     <= '0;
      r_s2     <= '0;
      r_fire   <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      for (int a = 0; a < AXES; a++) begin
        r_pos[a] <= '0;
        r_mem[a] <= '0;
      end
    end else begin
      r_s1 <= ui_in;
      r_s2 <= r_s1;
      if (w_wr_ctrl) begin
        r_enable <= bus.data_in[0];
        r_thr    <= bus.data_in[TW+7:8];
      end
      if (w_wr_leak)  r_leak  <= bus.data_in[15:0];
      if (w_wr_bound) r_bound <= bus.data_in[POS_W-1:0];
      // Setting wins over a write-one-to-clear landing in the same cycle.
      if (w_ovf_set)                             r_ovf  <= 1'b1;
      else if (w_wr_stat && bus.data_in[8])      r_ovf  <= 1'b0;
      if (w_bnd_set)                             r_birq <= 1'b1;
      else if (w_wr_stat && bus.data_in[9])      r_birq <= 1'b0;
      if (w_sclr) begin
        r_lcnt <= '0;
        r_fire <= '0;
        r_wp   <= '0;
        r_rp   <= '0;
        r_cnt  <= '0;
        for (int a = 0; a < AXES; a++) begin
          r_pos[a] <= '0;
          r_mem[a] <= '0;
        end
      end else begin
        if (r_enable && r_leak != '0) r_lcnt <= w_tick ? '0 : r_lcnt + 16'd1;
        r_fire <= r_enable ? w_fire_nxt : '0;
        if (r_enable) begin
          for (int a = 0; a < AXES; a++) begin
            r_pos[a] <= w_pos_nxt[a];
            r_mem[a] <= w_mem_nxt[a];
          end
        end
        if (w_push_ok) r_wp <= r_wp + AW'(1);
        if (w_pop)     r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + CW'(w_push_ok) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wp] <= bus.data_in[18:0];
  end

  always_comb begin
    bus.data_out = '0;
    if (bus.address[1:0] == 2'b00) begin
      case (bus.address[5:2])
        4'h0: begin
          bus.data_out[0]      = r_enable;
          bus.data_out[TW+7:8] = r_thr;
        end
        4'h1: bus.data_out[15:0] = r_leak;
        4'h3: begin
          bus.data_out[3:0] = 4'(r_cnt);
          bus.data_out[4]   = w_full;
          bus.data_out[5]   = w_empty;
          bus.data_out[8]   = r_ovf;
          bus.data_out[9]   = r_birq;
        end
        4'h4: bus.data_out[POS_W-1:0] = r_bound;
        4'h8, 4'h9, 4'hA, 4'hB: begin
          for (int a = 0; a < AXES; a++)
            if (bus.address[3:2] == 2'(a)) bus.data_out = 32'(r_pos[a]);
        end
        4'hC, 4'hD, 4'hE, 4'hF: begin
          for (int a = 0; a < AXES; a++)
            if (bus.address[3:2] == 2'(a)) bus.data_out = 32'(r_mem[a]);
        end
        default: bus.data_out = '0;
      endcase
    end
  end
endmodule
